uart_tx_to_pc: RTL
==================

// Module: uart_tx_to_pc
// PURPOSE
//  UART transmitter driving the board's serial line to the PC (Minisys_Uart_ToPc).
//  Buffers bytes in a small FIFO; frames each as 8N1, LSB first.
//  Counterpart of the receive path used for .coe download; carries CPU/debug output to the host.
// PARAMETERS
//  CLK_HZ      100_000_000  iFpgaClk frequency in Hz
//  BAUD        115200       line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit, DIV >= 2
//  FIFO_DEPTH  16           FIFO entries, power of two, >= 2
// PORTS
//  iFpgaClk       in   1   system clock, all logic on rising edge
//  iFpgaRstN      in   1   asynchronous reset, active-low
//  iWriteEnable   in   1   push iWriteData this cycle
//  iWriteData     in   8   byte to send
//  oFull          out  1   FIFO full; a write while high is dropped
//  oOverflow      out  1   one-cycle pulse: write dropped because full
//  oBusy          out  1   frame in progress or FIFO non-empty
//  oFifoCount     out  $clog2(FIFO_DEPTH)+1   entries buffered
//  oFpgaUartToPc  out  1   serial line, idle high, registered
// BEHAVIOUR
//  Reset (async, iFpgaRstN=0): oFpgaUartToPc=1; oFull=0; oOverflow=0; oBusy=0; oFifoCount=0.
//   FSM->IDLE; FIFO and counters cleared immediately, even mid-frame.
//   The partially sent byte is lost.
//  FIFO push: accepted on the rising edge when iWriteEnable=1 and oFull=0 (pre-edge value).
//   Write with oFull=1 is ignored and oOverflow=1 for that next cycle,
//   including when a pop occurs on the same edge.
//  Simultaneous push+pop (not full): both occur; count unchanged; pointers wrap mod FIFO_DEPTH.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE: line=1; if FIFO non-empty: pop into shift reg, go START.
//   START: line=0 for DIV clocks -> DATA, bit index 0.
//   DATA: line=shift[0] for DIV clocks; shift right, index+1; after bit 7 -> STOP.
//   STOP: line=1 for DIV clocks; then, if FIFO non-empty, pop and go directly START (no idle gap);
//    else IDLE.
//  Latency: byte written at edge N into an empty FIFO while IDLE.
//   Pop at edge N+1; line low from edge N+2 (registered output).
//  Bit timing: a single baud counter runs 0..DIV-1 and is cleared on every state entry.
//   Each bit is exactly DIV clocks; a frame is exactly 10*DIV clocks.
//  oBusy = (state != IDLE) | (oFifoCount != 0).
//  oFull = (oFifoCount == FIFO_DEPTH).
//  iWriteData is sampled only on the accepting edge; later changes do not affect the queued byte.
// STRUCTURE
//  uart_defs.vh (shared with the receiver): state encodings, the DIV calculation macro,
//   data/stop bit counts.
//  Sub-module uart_tx_fifo: sync FIFO with push, pop, dout, count, full and empty.
//  This top holds the FSM, the baud counter and the shift register.
// TESTING  (CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10; FIFO_DEPTH=4)
//  1. Write 0xA5 once -> line at edge N+2: 0 (10 clk), then 1,0,1,0,0,1,0,1 (10 clk each),
//     then 1 (10 clk); oBusy low after 100 clocks.
//  2. Write 0x01,0x02,0x03 back-to-back -> three frames, 300 contiguous clocks, no idle gap;
//     the decoded bytes match.
//  3. Write 6 bytes in consecutive cycles while idle -> 5 accepted (1 popped + 4 queued);
//     oFull=1; 6th drops with a one-cycle oOverflow pulse.
//  4. Push on the same edge as a pop with FIFO full -> push dropped, oOverflow=1,
//     oFifoCount = FIFO_DEPTH-1.
//  5. Assert iFpgaRstN=0 during bit 3 of 0x3C -> line=1 within the same cycle; count=0;
//     after release, idle until a new write.
//  6. Change iWriteData the cycle after an accepted write of 0x55 -> transmitted byte is 0x55.

Source files
------------

// File: rtl/uart_tx_to_pc_pkg.sv
// Shared definitions for the PC-bound UART path: FSM state encodings,
// frame geometry and the clocks-per-bit calculation.
package uart_tx_to_pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS = 8;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering bytes for the UART transmitter.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_din    write request and data (ignored while full)
//   i_pop            read request (ignored while empty)
//   o_dout           head entry (valid while not empty)
//   o_count          entries held, 0..DEPTH
//   o_full, o_empty  status flags
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/uart_tx_to_pc.sv
// UART transmitter to the host PC: FIFO-buffered, 8N1, LSB first.
// Ports:
//   iFpgaClk       system clock
//   iFpgaRstN      asynchronous reset, active-low
//   iWriteEnable   push iWriteData this cycle
//   iWriteData     byte to send
//   oFull          FIFO full (writes dropped)
//   oOverflow      one-cycle pulse after a dropped write
//   oBusy          frame in progress or FIFO non-empty
//   oFifoCount     entries buffered
//   oFpgaUartToPc  serial line, idle high, registered
module uart_tx_to_pc
  import uart_tx_to_pc_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          iFpgaClk,
  input  logic                          iFpgaRstN,
  input  logic                          iWriteEnable,
  input  logic [7:0]                    iWriteData,
  output logic                          oFull,
  output logic                          oOverflow,
  output logic                          oBusy,
  output logic [$clog2(FIFO_DEPTH):0]   oFifoCount,
  output logic                          oFpgaUartToPc
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned BW  = $clog2(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e  r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_line;
  logic          r_ovf;

  logic [7:0]    w_fifo_dout;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_baud_done;
  logic          w_pop;
  logic          w_line_nxt;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (iFpgaClk),
    .i_rst_n (iFpgaRstN),
    .i_push  (iWriteEnable),
    .i_din   (iWriteData),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (oFifoCount),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_baud_done = (r_baud == BAUD_LAST);
  // Pop from IDLE, or at the end of STOP so the next START follows with no gap.
  assign w_pop = ~w_fifo_empty &
                 ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_baud_done));

  // The line is registered from the current state, so it lags the state by
  // one clock: a pop at edge N+1 shows the start bit from edge N+2.
  always_comb begin
    w_line_nxt = 1'b1;
    case (r_state)
      ST_START: w_line_nxt = 1'b0;
      ST_DATA:  w_line_nxt = r_shift[0];
      default:  w_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge iFpgaClk or negedge iFpgaRstN) begin
    if (!iFpgaRstN) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_line    <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_line <= w_line_nxt;
      r_ovf  <= iWriteEnable & w_fifo_full;
      case (r_state)
        ST_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_fifo_dout;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == BIT_LAST) r_state <= ST_STOP;
            else                       r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        ST_STOP: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_fifo_dout;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oFpgaUartToPc = r_line;
  assign oOverflow     = r_ovf;
  assign oFull         = w_fifo_full;
  assign oBusy         = (r_state != ST_IDLE) | (oFifoCount != '0);

endmodule
